// File: rtl/alarm_qualifier.sv
// Qualifies a strobed comparator result into a debounced alarm level, counts
// alarm assertions and flags a stalled comparator.
module alarm_qualifier #(
    parameter int ASSERT_N   = 4,
    parameter int DEASSERT_N = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       result_valid,
    input  logic       comparison_result,
    input  logic       clear_count,
    output logic       alarm,
    output logic       alarm_rise,
    output logic [7:0] event_count,
    output logic       stale
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ALARM,
        RELEASE
    } state_t;

    localparam logic [3:0]  ASSERT_RUN   = 4'(ASSERT_N);
    localparam logic [3:0]  DEASSERT_RUN = 4'(DEASSERT_N);
    localparam logic [15:0] TIMEOUT_CNT  = 16'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    logic [3:0]  run;
    logic [3:0]  run_next;
    logic [3:0]  run_inc;
    logic        rise_next;
    logic [15:0] idle_cnt;
    logic [15:0] idle_next;

    // Run counter tracks consecutive samples that oppose the current alarm level.
    always_comb begin
        state_next = state;
        run_next   = run;
        rise_next  = 1'b0;
        run_inc    = run + 4'd1;
        if (result_valid) begin
            case (state)
                IDLE: begin
                    if (comparison_result) begin
                        if (ASSERT_RUN == 4'd1) begin
                            state_next = ALARM;
                            run_next   = 4'd0;
                            rise_next  = 1'b1;
                        end else begin
                            state_next = PENDING;
                            run_next   = 4'd1;
                        end
                    end else begin
                        run_next = 4'd0;
                    end
                end
                PENDING: begin
                    if (comparison_result) begin
                        if (run_inc == ASSERT_RUN) begin
                            state_next = ALARM;
                            run_next   = 4'd0;
                            rise_next  = 1'b1;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        state_next = IDLE;
                        run_next   = 4'd0;
                    end
                end
                ALARM: begin
                    if (!comparison_result) begin
                        if (DEASSERT_RUN == 4'd1) begin
                            state_next = IDLE;
                            run_next   = 4'd0;
                        end else begin
                            state_next = RELEASE;
                            run_next   = 4'd1;
                        end
                    end else begin
                        run_next = 4'd0;
                    end
                end
                RELEASE: begin
                    if (!comparison_result) begin
                        if (run_inc == DEASSERT_RUN) begin
                            state_next = IDLE;
                            run_next   = 4'd0;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        state_next = ALARM;
                        run_next   = 4'd0;
                    end
                end
            endcase
        end

        if (result_valid) begin
            idle_next = 16'd0;
        end else if (idle_cnt == TIMEOUT_CNT) begin
            idle_next = idle_cnt;
        end else begin
            idle_next = idle_cnt + 16'd1;
        end
    end

    // Outputs are registered from next-state values so they align with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            run         <= 4'd0;
            alarm       <= 1'b0;
            alarm_rise  <= 1'b0;
            event_count <= 8'd0;
            idle_cnt    <= 16'd0;
            stale       <= 1'b0;
        end else begin
            state      <= state_next;
            run        <= run_next;
            alarm      <= (state_next == ALARM) || (state_next == RELEASE);
            alarm_rise <= rise_next;
            if (clear_count) begin
                event_count <= 8'd0;
            end else if (rise_next && (event_count != 8'hFF)) begin
                event_count <= event_count + 8'd1;
            end
            idle_cnt <= idle_next;
            stale    <= (idle_next == TIMEOUT_CNT);
        end
    end

endmodule

// File: doc/alarm_qualifier.md
ALARM_QUALIFIER -- requirements
Module: alarm_qualifier

Interface
REQ-001 Parameter ASSERT_N, default 4, SHALL set the consecutive "1" results needed to raise the alarm; legal range 1..15.
REQ-002 Parameter DEASSERT_N, default 4, SHALL set the consecutive "0" results needed to drop the alarm; legal range 1..15.
REQ-003 Parameter TIMEOUT, default 1000, SHALL set the clock cycles without a result before stale asserts; legal range 1..65535.
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  SHALL be synchronous and active-high.
REQ-006 result_valid  input  1  SHALL be a one-cycle strobe marking a new comparator result (the comparator's compare_done).
REQ-007 comparison_result  input  1  SHALL be the comparator output, sampled only when result_valid=1.
REQ-008 clear_count  input  1  SHALL clear event_count when high.
REQ-009 alarm  output  1  SHALL be the qualified, registered alarm level.
REQ-010 alarm_rise  output  1  SHALL be a one-cycle pulse, high in the first cycle alarm reads 1.
REQ-011 event_count  output  8  SHALL count alarm assertions, saturating.
REQ-012 stale  output  1  SHALL flag the absence of results for TIMEOUT cycles.

Function
REQ-013 The FSM SHALL have states IDLE, PENDING, ALARM and RELEASE, plus a 4-bit run counter.
REQ-014 The FSM SHALL change state and run counter only in cycles with result_valid=1; otherwise it holds.
REQ-015 IDLE, result 1: run=1, next PENDING; if ASSERT_N=1, next ALARM. IDLE, result 0: stay, run=0.
REQ-016 PENDING, result 1: run+1; on reaching ASSERT_N, next ALARM and run=0. PENDING, result 0: next IDLE, run=0.
REQ-017 ALARM, result 0: run=1, next RELEASE; if DEASSERT_N=1, next IDLE. ALARM, result 1: stay, run=0.
REQ-018 RELEASE, result 0: run+1; on reaching DEASSERT_N, next IDLE and run=0. RELEASE, result 1: next ALARM, run=0.
REQ-019 alarm SHALL be 1 exactly when the state is ALARM or RELEASE.
REQ-020 alarm SHALL rise in the cycle after the result_valid strobe that completes the assert run (latency 1 cycle).
REQ-021 alarm_rise SHALL pulse only on the IDLE/PENDING->ALARM transition, never on RELEASE->ALARM.
REQ-022 event_count SHALL increment by 1 on each alarm_rise and saturate at 255 (no wrap).
REQ-023 If clear_count and an increment occur in the same cycle, clear SHALL win and event_count SHALL become 0.
REQ-024 An internal 16-bit idle counter SHALL be 0 after any cycle with result_valid=1; otherwise it SHALL increment, saturating at TIMEOUT.
REQ-025 stale SHALL be registered as 1 when the idle counter equals TIMEOUT, and 0 otherwise.
REQ-026 stale SHALL clear in the cycle after the next result_valid.
REQ-027 stale SHALL NOT alter FSM state, alarm or event_count.
REQ-028 result_valid held high for several cycles SHALL count as one sample per cycle.

Reset
REQ-029 reset=1 at a rising edge SHALL force state IDLE and run, idle counter, alarm, alarm_rise, event_count and stale to 0, with priority over all other inputs.
REQ-030 A reset asserted mid-run (PENDING or RELEASE) SHALL discard the partial run; counting restarts from the first valid sample after reset deasserts.

Verification
REQ-031 Defaults, four strobes with result=1 spaced 3 cycles apart -> alarm=1 and alarm_rise=1 one cycle after the 4th strobe; event_count=1.
REQ-032 Pattern 1,1,1,0,1,1,1,1 -> alarm stays 0 through the 0; alarm rises only after the final 4-run; event_count=1.
REQ-033 In ALARM, pattern 0,0,0,1,0,0,0,0 -> alarm stays 1 through the 1 with no alarm_rise; alarm falls one cycle after the 4th consecutive 0.
REQ-034 Force 256 alarm cycles -> event_count=255; then clear_count coincident with a new alarm_rise -> event_count=0.
REQ-035 TIMEOUT=10, no strobe for 10 cycles -> stale=1; then one strobe -> stale=0 on the next cycle; alarm unchanged.
REQ-036 Reset after 3 of 4 assert samples, then 3 more 1-strobes -> alarm still 0; the 4th strobe raises it.
